// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges two writeback requesters onto one register-file
// write port and keeps a pending-write scoreboard for the issue stage.
module rf_wb_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        rsv_en,
    input  logic [4:0]  rsv_addr,
    output logic [31:0] busy,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    localparam bit FixedPrio = (RR_EN == 0);

    logic        last_b_q;   // 1: B won the last transfer, so A wins the next tie
    logic [31:0] busy_q, busy_d;
    logic        we3_q;
    logic [4:0]  wa3_q;
    logic [31:0] wd3_q;

    logic        tie_to_a;
    logic        xfer_a, xfer_b, xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grant decode: only valids and the pointer feed ready, never addr/data.
    always_comb begin
        tie_to_a = FixedPrio || last_b_q;
        a_ready  = !rst && a_valid && (!b_valid || tie_to_a);
        b_ready  = !rst && b_valid && (!a_valid || !tie_to_a);
        xfer_a   = a_valid && a_ready;
        xfer_b   = b_valid && b_ready;
        xfer     = xfer_a || xfer_b;
        sel_addr = xfer_b ? b_addr : a_addr;
        sel_data = xfer_b ? b_data : a_data;
    end

    // Scoreboard next state: clear on writeback, then set on reserve so set wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != 5'd0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State: scoreboard, write port registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 32'd0;
            we3_q    <= 1'b0;
            wa3_q    <= 5'd0;
            wd3_q    <= 32'd0;
            last_b_q <= 1'b1;
        end else begin
            busy_q <= busy_d;
            // Writes to r0 are accepted but never issued to the register file.
            we3_q  <= xfer && (sel_addr != 5'd0);
            if (xfer) begin
                wa3_q    <= sel_addr;
                wd3_q    <= sel_data;
                last_b_q <= xfer_b;
            end
        end
    end

    assign busy = busy_q;
    assign we3  = we3_q;
    assign wa3  = wa3_q;
    assign wd3  = wd3_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, rsv_en;
    logic [4:0]  a_addr, b_addr, rsv_addr;
    logic [31:0] a_data, b_data;

    logic        a_ready_rr, b_ready_rr, we3_rr;
    logic [31:0] busy_rr, wd3_rr;
    logic [4:0]  wa3_rr;
    logic        a_ready_fp, b_ready_fp, we3_fp;
    logic [31:0] busy_fp, wd3_fp;
    logic [4:0]  wa3_fp;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_rr),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_rr),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_rr),
        .we3(we3_rr), .wa3(wa3_rr), .wd3(wd3_rr)
    );

    rf_wb_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_fp),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_fp),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_fp),
        .we3(we3_fp), .wa3(wa3_fp), .wd3(wd3_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_valid  = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid  = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        rsv_en   = 1'b0; rsv_addr = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        a_valid = 1'b1; a_addr = 5'd3; b_valid = 1'b1; b_addr = 5'd4;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        n_cmp++;
        if ({a_ready_rr, b_ready_rr, a_ready_fp, b_ready_fp} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000",
                     {a_ready_rr, b_ready_rr, a_ready_fp, b_ready_fp});
        end
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'd0 || we3_rr !== 1'b0 || wa3_rr !== 5'd0 || wd3_rr !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%h we3=%b wa3=%0d wd3=%h want all 0",
                     busy_rr, we3_rr, wa3_rr, wd3_rr);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    // Both requesters valid for 4 cycles, starting from the reset pointer.
    task automatic test_both();
        logic [4:0] exp_wa;
        exp_wa = 5'd0;
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                n_cmp++;
                if (we3_rr !== 1'b1 || wa3_rr !== exp_wa ||
                    wd3_rr !== ((exp_wa == 5'd1) ? 32'h11 : 32'h22)) begin
                    n_err++;
                    $display("FAIL both_rr_write[%0d]: we3=%b wa3=%0d wd3=%h want 1/%0d",
                             i, we3_rr, wa3_rr, wd3_rr, exp_wa);
                end
                n_cmp++;
                if (we3_fp !== 1'b1 || wa3_fp !== 5'd1 || wd3_fp !== 32'h11) begin
                    n_err++;
                    $display("FAIL both_fp_write[%0d]: we3=%b wa3=%0d wd3=%h want 1/1/11",
                             i, we3_fp, wa3_fp, wd3_fp);
                end
            end
            #1;
            exp_wa = (i % 2 == 0) ? 5'd1 : 5'd2;
            n_cmp++;
            if (a_ready_rr !== (i % 2 == 0) || b_ready_rr !== (i % 2 == 1)) begin
                n_err++;
                $display("FAIL both_rr_grant[%0d]: a_ready=%b b_ready=%b want %b %b",
                         i, a_ready_rr, b_ready_rr, (i % 2 == 0), (i % 2 == 1));
            end
            n_cmp++;
            if (a_ready_fp !== 1'b1 || b_ready_fp !== 1'b0) begin
                n_err++;
                $display("FAIL both_fp_grant[%0d]: a_ready=%b b_ready=%b want 1 0",
                         i, a_ready_fp, b_ready_fp);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (we3_rr !== 1'b1 || wa3_rr !== 5'd2 || wd3_rr !== 32'h22) begin
            n_err++;
            $display("FAIL both_rr_last: we3=%b wa3=%0d wd3=%h want 1/2/22",
                     we3_rr, wa3_rr, wd3_rr);
        end
        idle_inputs();
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (a_ready_rr !== 1'b1 || b_ready_rr !== 1'b0) begin
            n_err++;
            $display("FAIL single_a_ready: a_ready=%b b_ready=%b want 1 0",
                     a_ready_rr, b_ready_rr);
        end
        @(negedge clk);
        n_cmp++;
        if (we3_rr !== 1'b1 || wa3_rr !== 5'd5 || wd3_rr !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_a_write: we3=%b wa3=%0d wd3=%h want 1/5/deadbeef",
                     we3_rr, wa3_rr, wd3_rr);
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (we3_rr !== 1'b0 || wa3_rr !== 5'd5 || wd3_rr !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_a_idle: we3=%b wa3=%0d wd3=%h want 0/5/deadbeef (held)",
                     we3_rr, wa3_rr, wd3_rr);
        end
    endtask

    task automatic test_busy_clear();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'h80) begin
            n_err++;
            $display("FAIL rsv7_set: busy=%h want 00000080", busy_rr);
        end
        idle_inputs();
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        #1;
        n_cmp++;
        if (b_ready_rr !== 1'b1) begin
            n_err++;
            $display("FAIL b7_ready: b_ready=%b want 1", b_ready_rr);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'd0 || we3_rr !== 1'b1 || wa3_rr !== 5'd7 || wd3_rr !== 32'h77) begin
            n_err++;
            $display("FAIL b7_clear: busy=%h we3=%b wa3=%0d wd3=%h want 0/1/7/77",
                     busy_rr, we3_rr, wa3_rr, wd3_rr);
        end
        idle_inputs();
    endtask

    task automatic test_same_edge();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'h200 || we3_rr !== 1'b1 || wa3_rr !== 5'd9) begin
            n_err++;
            $display("FAIL set_wins: busy=%h we3=%b wa3=%0d want 00000200/1/9",
                     busy_rr, we3_rr, wa3_rr);
        end
        idle_inputs();
        // Write to a register that is not busy leaves the scoreboard alone.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'h200 || we3_rr !== 1'b1 || wa3_rr !== 5'd3 || wd3_rr !== 32'h33) begin
            n_err++;
            $display("FAIL nonbusy_write: busy=%h we3=%b wa3=%0d wd3=%h want 200/1/3/33",
                     busy_rr, we3_rr, wa3_rr, wd3_rr);
        end
        a_addr = 5'd9; a_data = 32'h9A;
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'd0) begin
            n_err++;
            $display("FAIL a9_clear: busy=%h want 0", busy_rr);
        end
        idle_inputs();
    endtask

    task automatic test_addr0();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        n_cmp++;
        if (a_ready_rr !== 1'b1) begin
            n_err++;
            $display("FAIL addr0_ready: a_ready=%b want 1", a_ready_rr);
        end
        @(negedge clk);
        n_cmp++;
        if (we3_rr !== 1'b0 || busy_rr !== 32'd0) begin
            n_err++;
            $display("FAIL addr0_write: we3=%b busy=%h want 0/0", we3_rr, busy_rr);
        end
        idle_inputs();
    endtask

    // Reset in the middle of traffic; the pointer was last left on A.
    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'h10 || we3_rr !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: busy=%h we3=%b want 10/1", busy_rr, we3_rr);
        end
        rst = 1'b1;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        rsv_addr = 5'd12;
        #1;
        n_cmp++;
        if (a_ready_rr !== 1'b0 || b_ready_rr !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_ready: a_ready=%b b_ready=%b want 0 0",
                     a_ready_rr, b_ready_rr);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_rr !== 32'd0 || we3_rr !== 1'b0 || wa3_rr !== 5'd0 || wd3_rr !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: busy=%h we3=%b wa3=%0d wd3=%h want all 0",
                     busy_rr, we3_rr, wa3_rr, wd3_rr);
        end
        rst = 1'b0;
        rsv_en = 1'b0;
        #1;
        n_cmp++;
        if (a_ready_rr !== 1'b1 || b_ready_rr !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_tie: a_ready=%b b_ready=%b want 1 0",
                     a_ready_rr, b_ready_rr);
        end
        @(negedge clk);
        n_cmp++;
        if (we3_rr !== 1'b1 || wa3_rr !== 5'd6 || wd3_rr !== 32'h66) begin
            n_err++;
            $display("FAIL post_reset_write: we3=%b wa3=%0d wd3=%h want 1/6/66",
                     we3_rr, wa3_rr, wd3_rr);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_both();
        test_single_a();
        test_busy_clear();
        test_same_edge();
        test_addr0();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, A over B.
REQ-002 clk  in  1  clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-005 a_addr  in  5  requester A destination register.
REQ-006 a_data  in  32  requester A write data.
REQ-007 a_ready  out  1  A accepted this cycle; combinational.
REQ-008 b_valid / b_addr / b_data / b_ready  in/in/in/out  1/5/32/1  requester B (load/multicycle unit), same meanings as A.
REQ-009 rsv_en  in  1  reserve rsv_addr as pending-write (issue stage).
REQ-010 rsv_addr  in  5  register to reserve.
REQ-011 busy  out  32  pending-write scoreboard, registered; busy[i]=1 means register i has an outstanding write.
REQ-012 we3 / wa3 / wd3  out  1/5/32  register-file write port, all registered.

Function
REQ-013 Handshake: transfer on X when x_valid && x_ready at posedge; at most one transfer per cycle in total.
REQ-014 x_ready SHALL depend only on current valids and the last-grant pointer; never on x_addr or x_data.
REQ-015 One valid only: that requester gets ready=1 in the same cycle.
REQ-016 Both valid, RR_EN=1: grant the requester not granted last; pointer updates only on a transfer.
REQ-017 Both valid, RR_EN=0: always grant A.
REQ-018 RR_EN=1: a continuously valid requester SHALL transfer within 2 cycles.
REQ-019 Latency: a transfer at edge N drives we3=1, wa3=addr, wd3=data for exactly the cycle after edge N.
REQ-020 No transfer: we3=0 next cycle; wa3 and wd3 hold their previous values.
REQ-021 Transfer with addr=0: accept normally (ready=1) and update the pointer, but we3=0.
REQ-022 busy bit set: rsv_en with rsv_addr!=0 sets busy[rsv_addr] at the next edge; rsv_addr=0 is ignored.
REQ-023 busy bit clear: a transfer to addr k clears busy[k] at the same edge.
REQ-024 Set and clear of the same bit at the same edge: set wins.
REQ-025 Transfer to a register whose busy bit is 0 is legal: the write is issued and busy is unchanged.
REQ-026 busy[0] SHALL be 0 at all times.

Reset
REQ-027 With rst=1 at an edge: busy=0, we3=0, wa3=0, wd3=0, and the pointer set so that A wins the next tie.
REQ-028 During the rst=1 cycle: a_ready=b_ready=0, no transfer, and rsv_en is ignored.
REQ-029 A request in flight when rst asserts is dropped; the requester SHALL re-present it after reset.

Verification
REQ-030 A valid only: a_addr=5, a_data=0xDEADBEEF at edge N -> a_ready=1 in cycle N; we3=1, wa3=5, wd3=0xDEADBEEF after edge N; we3=0 the following cycle.
REQ-031 Both valid continuously for 4 cycles, RR_EN=1 -> grant order A,B,A,B; we3=1 on each of the 4 cycles starting 1 cycle after the first grant.
REQ-032 Same stimulus, RR_EN=0 -> a_ready=1 on every cycle, b_ready=0 on every cycle.
REQ-033 rsv_en with rsv_addr=7; later B transfers addr 7 -> busy=0x80 after the rsv edge; busy=0 after the B transfer edge.
REQ-034 rsv_en with rsv_addr=9 and A transfer to addr 9 at the same edge -> busy[9]=1 after that edge and we3=1 with wa3=9.
REQ-035 A transfer to addr 0 with data 0x1234; rsv_en with rsv_addr=0 -> a_ready=1, we3 stays 0, busy stays 0; then rst for 1 cycle mid-traffic -> all outputs 0, and the next tie is granted to A.
